alu_muldiv: RTL and testbench

//  Next-generation execute unit for the multi-cycle MIPS datapath. It is a width-parametrised ALU

---
 rtl/alu_muldiv.sv | 184 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute unit for the multi-cycle MIPS datapath.
// Single-cycle ALU ops (add/sub/and/or/slt/sltu/xor/nor) plus iterative
// mult/multu (radix-2 shift-add) and div/divu (restoring) with HI/LO.
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for start; single-cycle ops and div-by-zero complete here
//   S_MUL   | one shift-add step per cycle, WIDTH steps
//   S_DIV   | one restoring quotient bit per cycle, WIDTH steps
//   S_FIX   | apply signs, write hi/lo/result, pulse done
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op, a, b   request (start sampled only while busy==0)
//   result, zero      registered result (LO for ops 8-11) and result==0
//   hi, lo            HI/LO registers
//   busy, done, div0  handshake and sticky divide-by-zero flag
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q;
    logic             zero_q, busy_q, done_q, div0_q;
    logic             is_div_q, neg_q, rem_neg_q;

    logic             op_md, op_div, op_sgn;
    logic [WIDTH-1:0] a_mag_d, b_mag_d, alu_d;
    logic [WIDTH:0]   mul_sum_d, div_trial_d, div_diff_d;
    logic [2*WIDTH-1:0] prod_neg_d;
    logic [WIDTH-1:0] fix_hi_d, fix_lo_d;

    assign op_md  = (op[3:2] == 2'b10);
    assign op_div = op[1];
    assign op_sgn = ~op[0];

    // Magnitudes are only taken for the signed variants.
    assign a_mag_d = (op_sgn && a[WIDTH-1]) ? -a : a;
    assign b_mag_d = (op_sgn && b[WIDTH-1]) ? -b : b;

    always_comb begin
        alu_d = '0;
        case (op)
            4'd0:    alu_d = a + b;
            4'd1:    alu_d = a - b;
            4'd2:    alu_d = a & b;
            4'd3:    alu_d = a | b;
            4'd4:    alu_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd5:    alu_d = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd6:    alu_d = a ^ b;
            4'd7:    alu_d = ~(a | b);
            default: alu_d = '0;
        endcase
    end

    // acc_hi/acc_lo hold partial product (mult) or remainder/dividend-quotient (div).
    assign mul_sum_d   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_trial_d = {acc_hi_q, acc_lo_q[WIDTH-1]};
    // diff[WIDTH] set means the trial was smaller than the divisor (restore).
    assign div_diff_d  = div_trial_d - {1'b0, opb_q};
    assign prod_neg_d  = -{acc_hi_q, acc_lo_q};

    always_comb begin
        fix_hi_d = acc_hi_q;
        fix_lo_d = acc_lo_q;
        if (!is_div_q) begin
            if (neg_q) {fix_hi_d, fix_lo_d} = prod_neg_d;
        end else begin
            if (neg_q)     fix_lo_d = -acc_lo_q;
            if (rem_neg_q) fix_hi_d = -acc_hi_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        div0_q <= 1'b0;
                        if (op_md && op_div && (b == '0)) begin
                            hi_q     <= a;
                            lo_q     <= '1;
                            result_q <= '1;
                            zero_q   <= 1'b0;
                            div0_q   <= 1'b1;
                            done_q   <= 1'b1;
                        end else if (op_md) begin
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
                            is_div_q  <= op_div;
                            neg_q     <= op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem_neg_q <= op_sgn & a[WIDTH-1];
                            acc_hi_q  <= '0;
                            if (op_div) begin
                                acc_lo_q <= a_mag_d;
                                opb_q    <= b_mag_d;
                                state_q  <= S_DIV;
                            end else begin
                                acc_lo_q <= b_mag_d;
                                opb_q    <= a_mag_d;
                                state_q  <= S_MUL;
                            end
                        end else begin
                            result_q <= alu_d;
                            zero_q   <= (alu_d == '0);
                            done_q   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi_q <= mul_sum_d[WIDTH:1];
                    acc_lo_q <= {mul_sum_d[0], acc_lo_q[WIDTH-1:1]};
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) state_q <= S_FIX;
                end
                S_DIV: begin
                    if (!div_diff_d[WIDTH]) begin
                        acc_hi_q <= div_diff_d[WIDTH-1:0];
                        acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_q <= div_trial_d[WIDTH-1:0];
                        acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q     <= fix_hi_d;
                    lo_q     <= fix_lo_d;
                    result_q <= fix_lo_d;
                    zero_q   <= (fix_lo_d == '0);
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign div0   = div0_q;
endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] a = '0, b = '0;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done, div0;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .result(result), .zero(zero), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div0(div0)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request now; it is sampled by the next rising edge.
    task automatic issue_now(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done; lat = cycle number of first done (-1 on timeout).
    // Optionally pulses an add request at cycle inj (0 = none).
    task automatic wait_done(input int inj, output int lat, output int busyc);
        lat = -1;
        busyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busyc++;
            if (c == inj) issue_now(4'd0, 32'd1, 32'd1);
        end
    endtask

    int lat, bc;

    initial begin
        vecs[0]  = '{4'd0,  32'd7,        32'd5,        32'd12,       1'b0};
        vecs[1]  = '{4'd1,  32'd5,        32'd5,        32'd0,        1'b1};
        vecs[2]  = '{4'd4,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
        vecs[3]  = '{4'd5,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[4]  = '{4'd7,  32'd0,        32'd0,        32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{4'd13, 32'd9,        32'd3,        32'd0,        1'b1};
        vecs[6]  = '{4'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
        vecs[7]  = '{4'd3,  32'h0F000000, 32'h000000F0, 32'h0F0000F0, 1'b0};
        vecs[8]  = '{4'd6,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1'b0};
        vecs[9]  = '{4'd1,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
        vecs[10] = '{4'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
        vecs[11] = '{4'd4,  32'h80000000, 32'h7FFFFFFF, 32'd1,        1'b0};
        vecs[12] = '{4'd5,  32'd1,        32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[13] = '{4'd15, 32'd1,        32'd2,        32'd0,        1'b1};

        #12;
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_hilo", {hi, lo}, 0);
        check("rst_hs", {busy, done, div0}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            issue_now(vecs[i].op, vecs[i].a, vecs[i].b);
            @(negedge clk);
            check($sformatf("vec%0d_done", i), done, 1);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_zero", i), zero, vecs[i].z);
            check($sformatf("vec%0d_hilo", i), {hi, lo}, 0);
        end
        @(negedge clk);
        check("done_drops", done, 0);

        // mult -3*7
        issue_now(4'd8, 32'hFFFFFFFD, 32'd7);
        wait_done(0, lat, bc);
        check("mult_lat", lat, 34);
        check("mult_busycyc", bc, 33);
        check("mult_busy_at_done", busy, 0);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        check("mult_result", result, 32'hFFFFFFEB);

        @(negedge clk);
        issue_now(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(0, lat, bc);
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);

        @(negedge clk);
        issue_now(4'd10, 32'hFFFFFFF9, 32'd2);
        wait_done(0, lat, bc);
        check("div_lat", lat, 34);
        check("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        @(negedge clk);
        issue_now(4'd10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(0, lat, bc);
        check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        @(negedge clk);
        issue_now(4'd11, 32'h100, 32'd0);
        wait_done(0, lat, bc);
        check("div0_lat", lat, 1);
        check("div0_flag", div0, 1);
        check("div0_hilo", {hi, lo}, 64'h00000100_FFFFFFFF);
        check("div0_result", result, 32'hFFFFFFFF);

        @(negedge clk);
        issue_now(4'd0, 32'd2, 32'd3);
        @(negedge clk);
        check("div0_clear", div0, 0);
        check("single_keeps_hilo", {hi, lo}, 64'h00000100_FFFFFFFF);

        @(negedge clk);
        issue_now(4'd11, 32'h100, 32'd7);
        wait_done(0, lat, bc);
        check("divu_hilo", {hi, lo}, 64'h00000004_00000024);

        // Ignored start mid-mult, then back-to-back issues in the done cycle.
        @(negedge clk);
        issue_now(4'd8, 32'd5, 32'hFFFFFFFB);
        wait_done(5, lat, bc);
        check("ign_lat", lat, 34);
        check("ign_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFE7);
        issue_now(4'd0, 32'd2, 32'd3);
        @(negedge clk);
        check("b2b_single_done", done, 1);
        check("b2b_single_result", result, 32'd5);
        issue_now(4'd9, 32'd3, 32'd4);
        @(negedge clk);
        check("b2b_md_accept", {busy, done}, 2'b10);
        wait_done(0, lat, bc);
        check("b2b_md_lat", lat, 33);
        check("b2b_md_lo", lo, 32'd12);

        // Reset mid-divide.
        @(negedge clk);
        issue_now(4'd11, 32'd1000, 32'd3);
        for (int c = 1; c < 10; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_result", result, 0);
        check("arst_zero", zero, 1);
        check("arst_hilo", {hi, lo}, 0);
        check("arst_hs", {busy, done, div0}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) bc++;
        end
        check("arst_no_done", bc, 0);
        issue_now(4'd0, 32'd1, 32'd1);
        @(negedge clk);
        check("post_rst_add", {done, result}, {1'b1, 32'd2});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
